alu8_cmd_sequencer: RTL and testbench

Command-issuing master for the combinational alu8 datapath. It accepts register-level commands over a valid/ready handshake and holds a small register file. For each command it drives alu8's a/b/op inputs, captures y and flags, writes the result back, and returns it on a valid/ready response channel. It is the initiator side of the alu8 operand/opcode interface. It sits between the instruction source (bench or future control FSM) and alu8.

---
 rtl/alu8_cmd_sequencer.sv | 129 ++++++++++++
 tb/tb_alu8_cmd_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu8_cmd_sequencer.sv
// alu8_cmd_sequencer: accepts register-level commands, drives the alu8
// operand/opcode inputs, writes the result back into a small register file
// and returns the result and flags on a valid/ready response channel.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a command; cmd_ready high
// EXEC  | registered operands on alu8; result captured at closing edge
// LOAD  | immediate written to rd at closing edge; flags untouched
// RESP  | res_valid high; held until res_ready
module alu8_cmd_sequencer #(
    parameter int DATA_W  = 8,
    parameter int REG_CNT = 4,
    parameter int AW      = $clog2(REG_CNT),
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_mode,
    input  logic [2:0]        cmd_op,
    input  logic [AW-1:0]     cmd_rd,
    input  logic [AW-1:0]     cmd_rs,
    input  logic [AW-1:0]     cmd_rt,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_zero,
    input  logic              alu_carry,
    input  logic              alu_overflow,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic              res_carry,
    output logic              res_overflow,
    input  logic [AW-1:0]     dbg_sel,
    output logic [DATA_W-1:0] dbg_data,
    output logic [CNT_W-1:0]  op_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_LOAD = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]        state;
    logic [DATA_W-1:0] regs [REG_CNT];
    logic [AW-1:0]     rd_q;
    logic [DATA_W-1:0] imm_q;

    assign cmd_ready = (state == S_IDLE);
    assign res_valid = (state == S_RESP);
    assign dbg_data  = regs[dbg_sel];

    // Sequencer FSM, command latch, alu8 drive and response registers.
    // Operands are registered at the accept edge: the register file cannot
    // change while IDLE, so this equals reading R[rs]/R[rt] in EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            rd_q         <= '0;
            imm_q        <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= 3'b000;
            res_data     <= '0;
            res_zero     <= 1'b0;
            res_carry    <= 1'b0;
            res_overflow <= 1'b0;
            op_count     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        rd_q  <= cmd_rd;
                        imm_q <= cmd_imm;
                        if (cmd_mode) begin
                            state <= S_LOAD;
                        end else begin
                            alu_a  <= regs[cmd_rs];
                            alu_b  <= regs[cmd_rt];
                            alu_op <= cmd_op;
                            state  <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    res_data     <= alu_y;
                    res_zero     <= alu_zero;
                    res_carry    <= alu_carry;
                    res_overflow <= alu_overflow;
                    alu_a        <= '0;
                    alu_b        <= '0;
                    alu_op       <= 3'b000;
                    state        <= S_RESP;
                end
                S_LOAD: begin
                    res_data <= imm_q;
                    state    <= S_RESP;
                end
                S_RESP: begin
                    if (res_ready) begin
                        op_count <= op_count + CNT_W'(1);
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Register file write-back at the closing edge of EXEC or LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs[i] <= '0;
            end
        end else if (state == S_EXEC) begin
            regs[rd_q] <= alu_y;
        end else if (state == S_LOAD) begin
            regs[rd_q] <= imm_q;
        end
    end

endmodule

// File: tb/tb_alu8_cmd_sequencer.sv
// Bench for alu8_cmd_sequencer: a behavioural alu8 stands in for the
// datapath, a reference model predicts every response, and a monitor
// compares responses against a scoreboard queue.
module tb_alu8_cmd_sequencer;

    localparam int DATA_W = 8;
    localparam int REG_CNT = 4;
    localparam int AW = 2;
    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_mode = 1'b0;
    logic [2:0]        cmd_op = 3'b000;
    logic [AW-1:0]     cmd_rd = '0;
    logic [AW-1:0]     cmd_rs = '0;
    logic [AW-1:0]     cmd_rt = '0;
    logic [DATA_W-1:0] cmd_imm = '0;
    logic [DATA_W-1:0] alu_a, alu_b, alu_y;
    logic [2:0]        alu_op;
    logic              alu_zero, alu_carry, alu_overflow;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [DATA_W-1:0] res_data;
    logic              res_zero, res_carry, res_overflow;
    logic [AW-1:0]     dbg_sel = '0;
    logic [DATA_W-1:0] dbg_data;
    logic [CNT_W-1:0]  op_count;

    int checks = 0;
    int errors = 0;

    // reference model state
    int unsigned ref_r [REG_CNT];
    logic        ref_z, ref_c, ref_v;
    int unsigned ref_count = 0;
    logic [10:0] exp_q [$];   // {ovf, carry, zero, data}
    int          bp_mode = 0; // 0 random, 1 force low, 2 force high

    alu8_cmd_sequencer #(
        .DATA_W(DATA_W), .REG_CNT(REG_CNT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
        .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
        .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_zero(res_zero), .res_carry(res_carry), .res_overflow(res_overflow),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Behavioural alu8: returns {ovf, carry, zero, y[7:0]}.
    function automatic logic [10:0] alu_fn(input logic [2:0] op, input int unsigned a, input int unsigned b);
        int unsigned y;
        int          sa, sb, sy;
        logic        c, v;
        c = 1'b0; v = 1'b0;
        sa = (a >= 128) ? int'(a) - 256 : int'(a);
        sb = (b >= 128) ? int'(b) - 256 : int'(b);
        case (op)
            3'd0: begin y = (a + b) % 256; c = (a + b) > 255; sy = sa + sb; v = (sy > 127) || (sy < -128); end
            3'd1: begin y = (a + 256 - b) % 256; c = a < b; sy = sa - sb; v = (sy > 127) || (sy < -128); end
            3'd2: y = a | b;
            3'd3: y = a & b;
            3'd4: y = a ^ b;
            3'd5: y = 255 - a;
            3'd6: begin y = (a * 2) % 256; c = a >= 128; end
            default: begin y = a / 2; c = (a % 2) == 1; end
        endcase
        return {v, c, (y == 0), 8'(y)};
    endfunction

    always_comb begin
        {alu_overflow, alu_carry, alu_zero, alu_y} = alu_fn(alu_op, alu_a, alu_b);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < REG_CNT; i++) ref_r[i] = 0;
        ref_z = 0; ref_c = 0; ref_v = 0;
        ref_count = 0;
        exp_q.delete();
    endtask

    // res_ready changes just after the rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                1: res_ready = 1'b0;
                2: res_ready = 1'b1;
                default: res_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: compares every presented response with the scoreboard head
    logic prev_hold = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && !res_valid) chk("res_valid_dropped", 0, 1);
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_response", 1, 0);
                end else begin
                    chk("response", {21'd0, res_overflow, res_carry, res_zero, res_data}, {21'd0, exp_q[0]});
                    if (res_ready) begin
                        void'(exp_q.pop_front());
                        ref_count++;
                    end
                end
            end
            prev_hold = res_valid && !res_ready;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_clear();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_res_data", res_data, 0);
        for (int i = 0; i < REG_CNT; i++) begin
            dbg_sel = AW'(i);
            #1 chk("rst_dbg", dbg_data, 0);
        end
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic issue(input logic mode, input logic [2:0] op, input logic [AW-1:0] rd,
                         input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [7:0] imm);
        int unsigned ea, eb, eop;
        logic [10:0] r;
        int n;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_mode = mode; cmd_op = op;
        cmd_rd = rd; cmd_rs = rs; cmd_rt = rt; cmd_imm = imm;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        ea = mode ? 0 : ref_r[rs];
        eb = mode ? 0 : ref_r[rt];
        eop = mode ? 0 : op;
        if (mode) begin
            ref_r[rd] = imm;
        end else begin
            r = alu_fn(op, ref_r[rs], ref_r[rt]);
            ref_r[rd] = r[7:0];
            {ref_v, ref_c, ref_z} = r[10:8];
        end
        exp_q.push_back({ref_v, ref_c, ref_z, 8'(ref_r[rd])});
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("stage_alu_a", alu_a, ea);
        chk("stage_alu_b", alu_b, eb);
        chk("stage_alu_op", alu_op, eop);
        chk("stage_res_valid_low", res_valid, 0);
        @(negedge clk);
        chk("latency_res_valid", res_valid, 1);
        chk("resp_alu_a_zero", alu_a, 0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        @(negedge clk);
        chk("op_count", op_count, ref_count[CNT_W-1:0]);
        chk("idle_cmd_ready", cmd_ready, 1);
    endtask

    task automatic chk_dbg(input int sel, input int unsigned exp);
        dbg_sel = AW'(sel);
        #1 chk("dbg_data", dbg_data, exp);
    endtask

    initial begin
        model_clear();
        #12;
        chk("init_cmd_ready", cmd_ready, 1);
        chk("init_res_valid", res_valid, 0);
        @(negedge clk);
        #1 rst = 1'b0;

        // mid-cycle reset
        do_reset();

        // LOAD 15, LOAD 10, ADD -> 25
        issue(1, 0, 0, 0, 0, 8'd15);
        issue(1, 0, 1, 0, 0, 8'd10);
        issue(0, 3'd0, 2, 0, 1, 8'd0);
        drain();
        chk_dbg(2, 25);
        chk("count3", op_count, 3);

        // ADD with carry, then LOAD keeps flags
        issue(1, 0, 0, 0, 0, 8'd200);
        issue(1, 0, 1, 0, 0, 8'd100);
        issue(0, 3'd0, 3, 0, 1, 8'd0);
        drain();
        chk_dbg(3, 44);
        chk("add_carry", res_carry, 1);
        issue(1, 0, 2, 0, 0, 8'd7);
        drain();
        chk("load_keeps_carry", res_carry, 1);
        chk("load_data", res_data, 7);

        // backpressure
        issue(1, 0, 0, 0, 0, 8'hAA);
        issue(1, 0, 1, 0, 0, 8'hCC);
        drain();
        @(negedge clk);
        bp_mode = 1;
        issue(0, 3'd4, 2, 0, 1, 8'd0);
        cmd_valid = 1'b1; cmd_mode = 1'b1; cmd_rd = 2'd3; cmd_imm = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_res_valid", res_valid, 1);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_res_data", res_data, 8'h66);
        end
        cmd_valid = 1'b0;
        chk_dbg(3, ref_r[3]);
        bp_mode = 2;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_idle", cmd_ready, 1);
        chk("bp_release_valid", res_valid, 0);
        bp_mode = 0;
        issue(1, 0, 3, 0, 0, 8'h55);
        drain();
        chk_dbg(3, 8'h55);

        // aliasing
        issue(1, 0, 0, 0, 0, 8'h0F);
        issue(0, 3'd6, 0, 0, 0, 8'd0);
        issue(0, 3'd1, 1, 1, 1, 8'd0);
        drain();
        chk_dbg(0, 8'h1E);
        chk("alias_sub_zero", res_zero, 1);
        chk("alias_sub_data", res_data, 0);

        // randomized commands
        for (int i = 0; i < 60; i++) begin
            issue(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), AW'($urandom),
                  AW'($urandom), AW'($urandom), 8'($urandom));
        end
        drain();
        for (int i = 0; i < REG_CNT; i++) chk_dbg(i, ref_r[i]);

        // reset during EXEC
        do_reset();
        issue(1, 0, 0, 0, 0, 8'd5);
        drain();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_mode = 1'b0; cmd_op = 3'd0; cmd_rd = 2'd3; cmd_rs = 2'd0; cmd_rt = 2'd0;
        begin
            int n = 0;
            while (!cmd_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("exec_alu_a", alu_a, 5);
        #2 rst = 1'b1;
        #1;
        model_clear();
        chk("exec_rst_alu_a", alu_a, 0);
        chk("exec_rst_alu_op", alu_op, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("exec_rst_no_resp", res_valid, 0);
        end
        chk_dbg(3, 0);
        chk_dbg(0, 0);
        chk("exec_rst_count", op_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
